alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that sits directly upstream of the 1-bit ALU. It accepts a WIDTH-bit operation through a start/busy/done handshake and streams operand bits to the ALU LSB-first, one bit per clock. It collects the ALU's 1-bit output into a WIDTH-bit result register. Carry-chain arithmetic is an optional build feature, so the ALU cell itself stays purely combinational.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit counter width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
op_select  input  2  ALU Select code, sampled at accept
op_mode  input  1  ALU Mode (0 logic, 1 arithmetic), sampled at accept
op_a  input  WIDTH  operand A, sampled at accept
op_b  input  WIDTH  operand B, sampled at accept
busy  output  1  high while bits are streaming
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  assembled result; held until next accept
carry_out  output  1  final carry (CARRY_CHAIN_EN only; else 0)
alu_select  output  2  to ALU Select
alu_mode  output  1  to ALU Mode
alu_a  output  1  to ALU A (current LSB of A shift register)
alu_b  output  1  to ALU B (current LSB of B shift register)
alu_out  input  1  from ALU Output (combinational return)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; busy=0; done=0; result=0; carry_out=0.
  - alu_select=2'b00; alu_mode=0; alu_a=0; alu_b=0; counter=0; carry flop=0.
- States:
  - IDLE: if start, load sregs from op_a/op_b, latch op_select/op_mode into alu_select/alu_mode, clear result, counter=0, carry=0, go SHIFT.
  - SHIFT: each cycle:
    - capture result <= {bit, result[WIDTH-1:1]};
    - shift both sregs right (zero-fill);
    - counter++.
    - When counter==WIDTH-1 after capture: go IDLE and pulse done next cycle.
- Timing:
  - Start accepted at edge 0.
  - SHIFT occupies edges 1..WIDTH.
  - done=1 and busy=0 during the cycle after edge WIDTH.
  - Latency is WIDTH+1 cycles from the accept edge to done visible.
- busy is 1 exactly while state==SHIFT.
- start while busy is ignored; no queuing.
- start during the done cycle is accepted (state is already IDLE), so back-to-back throughput is one operation per WIDTH+1 cycles.
- alu_select/alu_mode are held constant for the whole operation.
- alu_a/alu_b are registered, so the ALU sees stable inputs for the full cycle.
- Captured bit = alu_out (no feature) or alu_out ^ carry (feature, arithmetic codes).
- Asserting rst_n=0 mid-operation aborts immediately:
  - all outputs return to reset values;
  - no done pulse is generated for the aborted operation.
- Operand input changes after accept have no effect.

Optional Feature:
Macro: ALU_SERIAL_CARRY_CHAIN_EN.
- Defined:
  - Applies when alu_mode=1 and alu_select[1]=1.
  - Let a_eff = alu_a (select 10) or ~alu_a (select 11).
  - Captured bit = alu_out ^ carry.
  - carry <= majority(a_eff, alu_b, carry).
  - Carry-in is 0, so select 11 yields ~A+B.
  - carry_out = final carry, registered with the done pulse and held until the next accept.
  - Other codes leave carry at 0.
- Undefined:
  - Captured bit is the raw alu_out, i.e. per-bit modulo-2 behaviour.
  - carry_out is tied to 0 and the carry flop is absent.

Decomposition:
- Shared package alu_pkg holds:
  - select encodings SEL_PASS=2'b00, SEL_NOT=2'b01, SEL_XOR_ADD=2'b10, SEL_XNOR_SUB=2'b11;
  - MODE_LOGIC=0, MODE_ARITH=1;
  - state enum {IDLE, SHIFT}.
- One sub-module is natural: serial_carry_cell.
  - Computes a_eff, the corrected bit and the next carry.
  - Instantiated only under the macro.
- Counter, shift registers and FSM stay in the top.

Test Plan:
1. WIDTH=8, mode0 sel10, A=0xA5, B=0x3C, start pulse -> busy for 8 cycles, done at cycle 9, result=0x99.
2. mode0 sel01, A=0x0F -> result=0xF0. Then mode0 sel11, A=0xA5, B=0x3C -> 0x66. Run back-to-back, second start asserted in the done cycle and accepted.
3. mode1 sel10, A=0xFF, B=0x01 -> with macro: result=0x00, carry_out=1. Without macro: result=0xFE, carry_out=0.
4. mode1 sel11, A=0x05, B=0x10 -> with macro: result=0x0A, carry_out=1. Without macro: result=0xEA.
5. Assert start again at cycle 3 of an operation with different operands -> ignored; original result produced at cycle 9.
6. Drop rst_n at cycle 4 of an operation -> busy=0, result=0, alu_* =0 immediately; no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the 1-bit ALU and its bit-serial sequencer.
package alu_pkg;

  localparam logic [1:0] SEL_PASS     = 2'b00;
  localparam logic [1:0] SEL_NOT      = 2'b01;
  localparam logic [1:0] SEL_XOR_ADD  = 2'b10;
  localparam logic [1:0] SEL_XNOR_SUB = 2'b11;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Codes whose serial result depends on a carry from lower bits.
  function automatic logic is_carry_op(input logic mode, input logic [1:0] sel);
    return (mode == MODE_ARITH) && ((sel == SEL_XOR_ADD) || (sel == SEL_XNOR_SUB));
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response handshake between a client and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [1:0]       op_select;
  logic             op_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (output start, op_select, op_mode, op_a, op_b,
                  input  busy, done, result, carry_out);
  modport slave  (input  start, op_select, op_mode, op_a, op_b,
                  output busy, done, result, carry_out);
endinterface

// File: rtl/alu_serial_ctrl_carry_cell.sv
// Ripple-carry correction for one serial bit: turns the ALU's XOR/XNOR into add / ~A+B.
module serial_carry_cell (
  input  logic enable,
  input  logic invert_a,
  input  logic a,
  input  logic b,
  input  logic alu_bit,
  input  logic carry_in,
  output logic bit_out,
  output logic carry_next
);
  logic a_eff;

  assign a_eff      = a ^ invert_a;
  assign bit_out    = enable ? (alu_bit ^ carry_in) : alu_bit;
  assign carry_next = enable & ((a_eff & b) | (a_eff & carry_in) | (b & carry_in));
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer feeding a combinational 1-bit ALU, LSB first.
// Optional carry-chain arithmetic is built when ALU_SERIAL_CARRY_CHAIN_EN is defined.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_serial_ctrl_if.slave    ctrl,
  output logic [1:0]          alu_select,
  output logic                alu_mode,
  output logic                alu_a,
  output logic                alu_b,
  input  logic                alu_out
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sreg_a, sreg_b, result_q;
  logic             done_q;
  logic             accept, shifting, last_bit, cap_bit;

  assign accept   = (state_q == IDLE) && ctrl.start;
  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl.start) state_d = SHIFT;
      SHIFT:   if (last_bit)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the operand shift registers are reset too, since their LSBs drive alu_a/alu_b directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_a     <= '0;
      sreg_b     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      alu_select <= SEL_PASS;
      alu_mode   <= MODE_LOGIC;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        sreg_a     <= ctrl.op_a;
        sreg_b     <= ctrl.op_b;
        alu_select <= ctrl.op_select;
        alu_mode   <= ctrl.op_mode;
        result_q   <= '0;
        cnt_q      <= '0;
      end else if (shifting) begin
        result_q <= {cap_bit, result_q[WIDTH-1:1]};
        sreg_a   <= sreg_a >> 1;
        sreg_b   <= sreg_b >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (last_bit) done_q <= 1'b1;
      end
    end
  end

  assign alu_a       = sreg_a[0];
  assign alu_b       = sreg_b[0];
  assign ctrl.busy   = shifting;
  assign ctrl.done   = done_q;
  assign ctrl.result = result_q;

`ifdef ALU_SERIAL_CARRY_CHAIN_EN
  logic carry_q, carry_next, carry_out_q;

  serial_carry_cell u_carry (
    .enable     (is_carry_op(alu_mode, alu_select)),
    .invert_a   (alu_select == SEL_XNOR_SUB),
    .a          (alu_a),
    .b          (alu_b),
    .alu_bit    (alu_out),
    .carry_in   (carry_q),
    .bit_out    (cap_bit),
    .carry_next (carry_next)
  );

  // The final carry is published alongside done and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else if (shifting) begin
      carry_q <= carry_next;
      if (last_bit) carry_out_q <= carry_next;
    end
  end

  assign ctrl.carry_out = carry_out_q;
`else
  assign cap_bit        = alu_out;
  assign ctrl.carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl, paired with a behavioural 1-bit ALU.
`timescale 1ns/1ps
module tb_alu_serial_ctrl;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] alu_select;
  logic       alu_mode, alu_a, alu_b, alu_out;
  int         checks = 0;
  int         failures = 0;

  alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (bus),
    .alu_select (alu_select),
    .alu_mode   (alu_mode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out)
  );

  // Behavioural 1-bit ALU: PASS, NOT, XOR, XNOR regardless of mode.
  always_comb begin
    alu_out = 1'b0;
    case (alu_select)
      2'b00: alu_out = alu_a;
      2'b01: alu_out = ~alu_a;
      2'b10: alu_out = alu_a ^ alu_b;
      2'b11: alu_out = ~(alu_a ^ alu_b);
      default: alu_out = 1'b0;
    endcase
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Caller is at a negedge; start is held across exactly one rising edge.
  task automatic issue(input logic [1:0] sel, input logic mode,
                       input logic [7:0] a, input logic [7:0] b);
    bus.start     = 1'b1;
    bus.op_select = sel;
    bus.op_mode   = mode;
    bus.op_a      = a;
    bus.op_b      = b;
    @(posedge clk);
    #1 bus.start  = 1'b0;
  endtask

  // Counts negedges until done is seen; returns at the negedge inside the done cycle.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
    end while (!bus.done && lat < 20);
    if (!bus.done) check("done_timeout", 32'(lat), 32'(20 + 1));
  endtask

  int lat, busy_n, done_seen;

  initial begin
    bus.start = 1'b0; bus.op_select = 2'b00; bus.op_mode = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(bus.busy),      32'h0);
    check("rst_done",   32'(bus.done),      32'h0);
    check("rst_result", 32'(bus.result),    32'h0);
    check("rst_carry",  32'(bus.carry_out), 32'h0);
    check("rst_alu",    32'({alu_select, alu_mode, alu_a, alu_b}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: XOR, latency and busy length
    issue(2'b10, 1'b0, 8'hA5, 8'h3C);
    wait_done(lat, busy_n);
    check("t1_latency", 32'(lat),      32'(WIDTH + 1));
    check("t1_busy_n",  32'(busy_n),   32'(WIDTH));
    check("t1_busy_in_done", 32'(bus.busy), 32'h0);
    check("t1_result",  32'(bus.result), 32'h99);
    check("t1_carry",   32'(bus.carry_out), 32'h0);
    @(negedge clk);
    check("t1_done_pulse", 32'(bus.done), 32'h0);
    check("t1_result_held", 32'(bus.result), 32'h99);

    // 2: NOT then XNOR back-to-back, second start in the done cycle
    issue(2'b01, 1'b0, 8'h0F, 8'h00);
    wait_done(lat, busy_n);
    check("t2a_result", 32'(bus.result), 32'hF0);
    issue(2'b11, 1'b0, 8'hA5, 8'h3C);
    check("t2_b2b_busy", 32'(bus.busy), 32'h1);
    wait_done(lat, busy_n);
    check("t2b_latency", 32'(lat),       32'(WIDTH + 1));
    check("t2b_result",  32'(bus.result), 32'h66);

    // 3: arithmetic add FF + 01
    issue(2'b10, 1'b1, 8'hFF, 8'h01);
    wait_done(lat, busy_n);
`ifdef ALU_SERIAL_CARRY_CHAIN_EN
    check("t3_result", 32'(bus.result),    32'h00);
    check("t3_carry",  32'(bus.carry_out), 32'h1);
`else
    check("t3_result", 32'(bus.result),    32'hFE);
    check("t3_carry",  32'(bus.carry_out), 32'h0);
`endif

    // 4: arithmetic ~A + B with 05, 10; controls held mid-operation
    @(negedge clk);
    issue(2'b11, 1'b1, 8'h05, 8'h10);
    repeat (4) @(negedge clk);
    check("t4_sel_held",  32'(alu_select), 32'h3);
    check("t4_mode_held", 32'(alu_mode),   32'h1);
    wait_done(lat, busy_n);
    check("t4_latency", 32'(lat + 4), 32'(WIDTH + 1));
`ifdef ALU_SERIAL_CARRY_CHAIN_EN
    check("t4_result", 32'(bus.result),    32'h0A);
    check("t4_carry",  32'(bus.carry_out), 32'h1);
`else
    check("t4_result", 32'(bus.result),    32'hEA);
    check("t4_carry",  32'(bus.carry_out), 32'h0);
`endif

    // 5: second start at cycle 3 is ignored
    @(negedge clk);
    issue(2'b10, 1'b0, 8'h12, 8'h34);
    repeat (2) @(negedge clk);
    @(negedge clk);
    issue(2'b01, 1'b0, 8'hFF, 8'hFF);
    wait_done(lat, busy_n);
    check("t5_latency", 32'(lat + 3), 32'(WIDTH + 1));
    check("t5_result",  32'(bus.result),    32'h26);
    check("t5_carry",   32'(bus.carry_out), 32'h0);

    // 6: reset at cycle 4 aborts without done
    @(negedge clk);
    issue(2'b11, 1'b1, 8'hFF, 8'hFF);
    repeat (4) @(negedge clk);
    check("t6_pre_busy",  32'(bus.busy), 32'h1);
    check("t6_pre_alu_a", 32'(alu_a),    32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_busy",   32'(bus.busy),   32'h0);
    check("t6_result", 32'(bus.result), 32'h0);
    check("t6_alu",    32'({alu_select, alu_mode, alu_a, alu_b}), 32'h0);
    check("t6_carry",  32'(bus.carry_out), 32'h0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("t6_no_done", 32'(done_seen), 32'h0);
    issue(2'b00, 1'b0, 8'h5A, 8'h00);
    wait_done(lat, busy_n);
    check("t6_new_latency", 32'(lat),        32'(WIDTH + 1));
    check("t6_new_result",  32'(bus.result), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
